// File: rtl/hilo_seq_pkg.sv
// hilo_seq_pkg: shared state encoding and sizing constants for the HI/LO multiply sequencer. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

package hilo_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUN     = ST_RUN,
    CAPTURE = ST_CAPTURE
  } state_t;

  localparam int MULT_LATENCY_DEF = 32;
  localparam int CNT_W            = $clog2(MULT_LATENCY_DEF) + 1;

  // Counter width for a given latency; one spare bit keeps LATENCY-1 representable for any value.
  function automatic int cnt_width(input int latency);
    return $clog2(latency) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_seq_if.sv
// hilo_seq_if: control-unit, datapath and multiplier signals of the HI/LO sequencer. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface hilo_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] mult_hi_in;
  logic [WIDTH-1:0] mult_lo_in;
  logic             mult_op;
  logic [WIDTH-1:0] mult_a;
  logic [WIDTH-1:0] mult_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, op_a, op_b, hi_we, lo_we, wr_data, mult_hi_in, mult_lo_in,
    output mult_op, mult_a, mult_b, busy, done, hi, lo
  );

  modport master (
    output start, op_a, op_b, hi_we, lo_we, wr_data, mult_hi_in, mult_lo_in,
    input  mult_op, mult_a, mult_b, busy, done, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/hilo_seq.sv
// hilo_seq: holds the multiplier enable for MULT_LATENCY+1 edges, captures the product into HI/LO,
// and services direct HI/LO writes while idle. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module hilo_seq
  import hilo_seq_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input  wire       clk,
  input  wire       reset,
  hilo_seq_if.slave bus
);

  localparam int CW = cnt_width(MULT_LATENCY);
  localparam logic [CW-1:0] C_LAST = CW'(MULT_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mult_op_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mult_op_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Direct writes land first; a same-cycle start is later overwritten by the capture.
          if (bus.hi_we) hi_q <= bus.wr_data;
          if (bus.lo_we) lo_q <= bus.wr_data;
          if (bus.start) begin
            a_q       <= bus.op_a;
            b_q       <= bus.op_b;
            mult_op_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          mult_op_q <= 1'b1;
        end
        CAPTURE: begin
          // Enable is still high on this edge, so the multiplier is holding a valid product.
          hi_q      <= bus.mult_hi_in;
          lo_q      <= bus.mult_lo_in;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          mult_op_q <= 1'b0;
        end
        default: begin
          mult_op_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mult_op = mult_op_q;
  assign bus.mult_a  = a_q;
  assign bus.mult_b  = b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

`default_nettype wire

// File: doc/hilo_seq.md
# hilo_seq

Sequencer and HI/LO register pair for the multicycle CPU's multiply path. It latches the operands on a start pulse and holds the multiplier's operation enable for exactly the required number of edges. It captures the 64-bit product into HI/LO and signals completion to the control unit. It also services direct HI/LO writes and drives HI/LO continuously to the datapath muxes.

## Interface
- WIDTH, 32, operand and HI/LO width
- MULT_LATENCY, 32, number of rising edges the multiplier must see with its enable high before its hi/lo outputs are valid
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  input  1  single-cycle request from control unit to begin a multiply
- op_a  input  WIDTH  multiplicand (rs), sampled on the start edge
- op_b  input  WIDTH  multiplier (rt), sampled on the start edge
- hi_we  input  1  direct write to HI (mthi)
- lo_we  input  1  direct write to LO (mtlo)
- wr_data  input  WIDTH  data for hi_we/lo_we
- mult_hi_in  input  WIDTH  upper product word from multiplier
- mult_lo_in  input  WIDTH  lower product word from multiplier
- mult_op  output  1  enable to multiplier; registered
- mult_a  output  WIDTH  held multiplicand to multiplier
- mult_b  output  WIDTH  held multiplier to multiplier
- busy  output  1  high while a multiply is in flight
- done  output  1  one-cycle pulse; HI/LO hold the new product this cycle
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- Reset values: state IDLE, counter 0, mult_op 0, busy 0, done 0, mult_a/mult_b 0, hi 0, lo 0.
- States: IDLE, RUN, CAPTURE.
- IDLE:
  - start=1 latches op_a/op_b into mult_a/mult_b, clears counter, sets mult_op=1 and busy=1, and moves to RUN.
  - hi_we/lo_we write wr_data.
- RUN:
  - Counter increments every edge.
  - When counter == MULT_LATENCY-1, move to CAPTURE.
  - mult_op stays 1.
- CAPTURE:
  - mult_op is still 1 at this edge. The multiplier holds its result; it clears outputs only on an edge where its enable is low.
  - Writes mult_hi_in→hi and mult_lo_in→lo.
  - Sets done=1, busy=0, mult_op=0, and returns to IDLE.
- done is 0 in every cycle except the one following the CAPTURE edge.
- The product is the signed 64-bit result supplied by the multiplier; this block does not modify it.
- Boundary rules:
  - start while busy=1 is ignored.
  - hi_we/lo_we while busy=1 are dropped, including during the CAPTURE edge.
  - start and hi_we/lo_we in the same IDLE cycle: the write is applied and the multiply starts. The capture later overwrites both registers.
  - hi_we and lo_we together write wr_data to both.
  - reset at any point aborts the operation and forces all reset values at that edge. The multiplier sees mult_op=0 at the next edge and clears itself.
  - mult_a/mult_b stay constant from the start edge until the next accepted start. op_a/op_b changes after start have no effect.

## Timing
- Let E0 be the edge that samples start=1.
- mult_op is high after E0. The multiplier sees it at edges E1..E(MULT_LATENCY+1).
- Counter values at E1..E32 are 0..31. RUN→CAPTURE occurs at E32 (default parameters).
- hi/lo update at E33. done=1 during the cycle after E33. busy=1 from after E0 through E33.
- Start-to-done latency is MULT_LATENCY+1 cycles (33 by default).
- A new start is accepted in the done cycle, giving 34-cycle back-to-back issue.
- HI/LO reads are combinational from the registers, with zero added latency.

## Structure
- Shared package holds:
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, CAPTURE=2'd2)
  - MULT_LATENCY default
  - a counter width constant of $clog2(MULT_LATENCY)+1
- Single flat module; no sub-module. The multiplier is instantiated beside it by the datapath top, not inside.
- Counter, FSM and HI/LO writes in one clocked always block. Next-state decode may be split out.

## Test plan
- Reset, then check outputs → hi=lo=0, busy=0, done=0, mult_op=0.
- start, op_a=7, op_b=6 → mult_op high 33 cycles, done exactly 33 cycles after start edge, hi=0x00000000, lo=0x0000002A.
- start, op_a=0xFFFFFFFD (−3), op_b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then immediate start in done cycle with 0x10000, 0x10000 → hi=0x00000001, lo=0x00000000.
- IDLE writes and busy-time writes:
  - hi_we=1, wr_data=0xDEADBEEF in IDLE → hi=0xDEADBEEF next cycle, lo unchanged.
  - Same write during busy → dropped.
  - Second start during busy → ignored; operands unchanged and done count stays 1.
- Assert reset at cycle 15 of a multiply → next cycle all outputs 0. Then start 3×4 → lo=12 after 33 cycles, with no stale data.
